// File: rtl/window_3x3_ctrl.sv
// window_3x3_ctrl: sequencer for the 3x3 input-window datapath.
// Feeds three row fifos from BRAM and pops aligned windows to a valid/ready port.
module window_3x3_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_row_words,
    input  logic [CNT_W-1:0]  cfg_out_cols,
    input  logic [CNT_W-1:0]  cfg_out_rows,
    input  logic              cfg_stride2,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [63:0]       doutb,
    output logic              fifo_start,
    output logic              fifo_row_done,
    output logic              fifo_stride2,
    output logic [2:0]        fifo_push,
    output logic [63:0]       fifo_wdata,
    output logic              fifo_pop,
    input  logic [11:0]       fifo_count,
    input  logic [71:0]       fifo_rdata,
    output logic [71:0]       window_data,
    output logic              window_valid,
    input  logic              window_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_ROW_END, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      r_q, r_d, c_q, c_d, n_q, n_d;
    logic                  s2_q, s2_d;
    logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
    logic [2:0][CNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [2:0]            rd1_q, rd1_d, rd2_q, rd2_d;
    logic [71:0]           win_q, win_d;
    logic                  win_vld_q, win_vld_d;

    logic [2:0]        elig;
    logic [1:0]        cand;
    logic              rd_go;
    logic [1:0]        rd_idx;
    logic [ADDR_W-1:0] r_a, off, step, rd_addr;
    logic              cnt_ok, pop, row_fire;
    logic [CNT_W:0]    row_nxt;

    assign r_a     = ADDR_W'(r_q);
    assign step    = s2_q ? (r_a << 1) : r_a;
    assign row_nxt = {1'b0, row_cnt_q} + 1'b1;
    assign cnt_ok  = (fifo_count[3:0] >= 4'd3) &&
                     (fifo_count[7:4] >= 4'd3) &&
                     (fifo_count[11:8] >= 4'd3);
    assign pop      = (state_q == S_RUN) && (col_cnt_q < c_q) && cnt_ok &&
                      (!win_vld_q || window_ready);
    assign row_fire = (state_q == S_ROW_END) && (rd1_q == 3'b000);

    // Round-robin fetch arbitration and read address generation
    always_comb begin
        rd_go  = 1'b0;
        rd_idx = 2'd0;
        cand   = ptr_q;
        off    = '0;
        for (int i = 0; i < 3; i++) begin
            elig[i] = (wcnt_q[i] < r_q) && (fifo_count[4*i +: 4] <= 4'd7) &&
                      !rd1_q[i] && !rd2_q[i];
        end
        for (int k = 0; k < 3; k++) begin
            if (!rd_go && (state_q == S_RUN) && elig[cand]) begin
                rd_go  = 1'b1;
                rd_idx = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
        if (rd_idx == 2'd1) off = r_a;
        else if (rd_idx == 2'd2) off = r_a << 1;
        rd_addr = base_q + off + ADDR_W'(wcnt_q[rd_idx]);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_INIT;
            S_INIT:    state_d = (c_q == '0 || n_q == '0) ? S_DONE : S_RUN;
            S_RUN:     if (col_cnt_q == c_q) state_d = S_ROW_END;
            S_ROW_END: if (row_fire)
                           state_d = (row_nxt < {1'b0, n_q}) ? S_RUN : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Counters, config latches, read history and output window register
    always_comb begin
        r_d       = r_q;
        c_d       = c_q;
        n_d       = n_q;
        s2_d      = s2_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        wcnt_d    = wcnt_q;
        base_d    = base_q;
        ptr_d     = ptr_q;
        rd1_d     = rd_go ? (3'b001 << rd_idx) : 3'b000;
        rd2_d     = rd1_q;
        win_d     = win_q;
        win_vld_d = win_vld_q;
        if (state_q == S_IDLE && start) begin
            r_d       = cfg_row_words;
            c_d       = cfg_out_cols;
            n_d       = cfg_out_rows;
            s2_d      = cfg_stride2;
            row_cnt_d = '0;
            base_d    = '0;
        end
        if (state_q == S_INIT || row_fire) begin
            wcnt_d    = '0;
            col_cnt_d = '0;
            ptr_d     = 2'd0;
        end
        if (row_fire) begin
            row_cnt_d = row_cnt_q + 1'b1;
            base_d    = base_q + step;
        end
        if (rd_go) begin
            wcnt_d[rd_idx] = wcnt_q[rd_idx] + 1'b1;
            ptr_d          = (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
        end
        if (pop) begin
            col_cnt_d = col_cnt_q + 1'b1;
            win_d     = fifo_rdata;
            win_vld_d = 1'b1;
        end else if (win_vld_q && window_ready) begin
            win_vld_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            n_q       <= '0;
            s2_q      <= 1'b0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            wcnt_q    <= '0;
            base_q    <= '0;
            ptr_q     <= 2'd0;
            rd1_q     <= 3'b000;
            rd2_q     <= 3'b000;
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            n_q       <= n_d;
            s2_q      <= s2_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            wcnt_q    <= wcnt_d;
            base_q    <= base_d;
            ptr_q     <= ptr_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
        end
    end

    // Output decode; fifo data is only driven while a push is in progress
    always_comb begin
        enb           = rd_go;
        addrb         = rd_go ? rd_addr : '0;
        fifo_start    = (state_q == S_INIT);
        fifo_row_done = row_fire;
        fifo_stride2  = s2_q;
        fifo_push     = rd1_q;
        fifo_wdata    = (rd1_q != 3'b000) ? doutb : 64'd0;
        fifo_pop      = pop;
        window_data   = win_q;
        window_valid  = win_vld_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
    end

endmodule
